whack_game_engine: RTL and testbench

WHACK_GAME_ENGINE -- requirements
Module: whack_game_engine

---
 rtl/whack_game_engine.sv | 155 +++++++++++++++
 tb/tb_whack_game_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_engine.sv
// Whack-a-mole game engine: game FSM, LFSR-driven mole spawning, per-hole lifetimes, score/escape counters.
// Optional MISS_PENALTY_EN: a hit on an empty hole decrements the score (saturating at 0).
module whack_game_engine #(
  parameter int unsigned     N_HOLES          = 9,
  parameter int unsigned     SCORE_W          = 8,
  parameter longint unsigned GAME_CYCLES      = 64'd3_000_000_000,
  parameter longint unsigned SPAWN_CYCLES     = 64'd50_000_000,
  parameter longint unsigned MOLE_LIFE_CYCLES = 64'd150_000_000,
  parameter int unsigned     WIN_SCORE        = 10,
  parameter logic [15:0]     LFSR_SEED        = 16'hACE1,
  localparam int unsigned    IDX_W            = $clog2(N_HOLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit_valid,
  input  logic [IDX_W-1:0]   hit_pos,
  output logic [1:0]         game_state,
  output logic [N_HOLES-1:0] mole_map,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] escapes,
  output logic               hit_ack
);

  localparam int unsigned GT_W  = (GAME_CYCLES > 1) ? $clog2(GAME_CYCLES) : 1;
  localparam int unsigned SP_W  = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
  localparam int unsigned LF_W  = (MOLE_LIFE_CYCLES > 1) ? $clog2(MOLE_LIFE_CYCLES) : 1;
  localparam int unsigned IDX1_W = IDX_W + 1;
  localparam int unsigned P2_W  = 1 << IDX_W;

  localparam logic [GT_W-1:0]    GAME_LAST  = GT_W'(GAME_CYCLES - 1);
  localparam logic [SP_W-1:0]    SPAWN_LAST = SP_W'(SPAWN_CYCLES - 1);
  localparam logic [LF_W-1:0]    LIFE_LAST  = LF_W'(MOLE_LIFE_CYCLES - 1);
  localparam logic [IDX_W:0]     N_HOLES_C  = IDX1_W'(N_HOLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_C      = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAME = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic [GT_W-1:0]   game_timer;
  logic [SP_W-1:0]   spawn_cnt;
  logic [LF_W-1:0]   life_cnt [N_HOLES];

  logic [P2_W-1:0]    map_ext;
  logic               pos_ok;
  logic [IDX_W-1:0]   spawn_idx;
  logic               hit_now;
  logic               spawn_now;
  logic [N_HOLES-1:0] hit_mask;
  logic [N_HOLES-1:0] spawn_mask;
  logic [N_HOLES-1:0] expire;
  logic [N_HOLES-1:0] next_map;
  logic [SCORE_W-1:0] next_score;
  logic [SCORE_W-1:0] next_esc;
`ifdef MISS_PENALTY_EN
  logic               miss_now;
`endif

  assign game_state = state;

  // Per-cycle hit/spawn/expiry decisions and next values of the game counters
  always_comb begin
    hit_now    = 1'b0;
    spawn_now  = 1'b0;
    hit_mask   = '0;
    spawn_mask = '0;
    expire     = '0;
    map_ext    = P2_W'(mole_map);
    pos_ok     = {1'b0, hit_pos} < N_HOLES_C;
    spawn_idx  = lfsr[IDX_W-1:0];
    if ({1'b0, spawn_idx} >= N_HOLES_C) spawn_idx = spawn_idx - N_HOLES_C[IDX_W-1:0];
`ifdef MISS_PENALTY_EN
    miss_now   = 1'b0;
`endif
    if (state == S_GAME) begin
      hit_now   = hit_valid && pos_ok && map_ext[hit_pos];
      spawn_now = (spawn_cnt == SPAWN_LAST) && !map_ext[spawn_idx] &&
                  !(hit_now && (hit_pos == spawn_idx));
      for (int i = 0; i < N_HOLES; i++) expire[i] = mole_map[i] && (life_cnt[i] == LIFE_LAST);
`ifdef MISS_PENALTY_EN
      miss_now  = hit_valid && pos_ok && !map_ext[hit_pos];
`endif
    end
    if (hit_now)   hit_mask   = N_HOLES'(1) << hit_pos;
    if (spawn_now) spawn_mask = N_HOLES'(1) << spawn_idx;
    next_map   = (mole_map & ~(hit_mask | expire)) | spawn_mask;
    next_score = score;
    if (hit_now && (score != SCORE_MAX)) next_score = score + SCORE_W'(1);
`ifdef MISS_PENALTY_EN
    if (miss_now && (score != '0)) next_score = score - SCORE_W'(1);
`endif
    // Spawns are one per interval, so at most one mole can expire per cycle
    next_esc = escapes;
    if ((|(expire & ~hit_mask)) && (escapes != SCORE_MAX)) next_esc = escapes + SCORE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      game_timer <= '0;
      spawn_cnt  <= '0;
      mole_map   <= '0;
      score      <= '0;
      escapes    <= '0;
      hit_ack    <= 1'b0;
      for (int i = 0; i < N_HOLES; i++) life_cnt[i] <= '0;
    end else begin
      lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      hit_ack <= hit_now;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_GAME;
            game_timer <= '0;
            spawn_cnt  <= '0;
            mole_map   <= '0;
            score      <= '0;
            escapes    <= '0;
            for (int i = 0; i < N_HOLES; i++) life_cnt[i] <= '0;
          end
        end
        S_GAME: begin
          game_timer <= game_timer + GT_W'(1);
          spawn_cnt  <= (spawn_cnt == SPAWN_LAST) ? '0 : spawn_cnt + SP_W'(1);
          mole_map   <= next_map;
          score      <= next_score;
          escapes    <= next_esc;
          for (int i = 0; i < N_HOLES; i++) begin
            if (spawn_mask[i])                life_cnt[i] <= '0;
            else if (mole_map[i] && !expire[i]) life_cnt[i] <= life_cnt[i] + LF_W'(1);
          end
          // Win is checked first so it takes priority over a simultaneous timeout
          if (score >= WIN_C) begin
            state    <= S_WIN;
            mole_map <= '0;
          end else if (game_timer == GAME_LAST) begin
            state    <= S_LOSE;
            mole_map <= '0;
          end
        end
        S_WIN, S_LOSE: if (start) state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_game_engine.sv
// Scoreboard bench for whack_game_engine: stimulus queues expectations, a negedge monitor compares them.
module tb_whack_game_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst, start, hit_valid;
  logic [1:0]    hit_pos;
  logic [1:0]    game_state;
  logic [N-1:0]  mole_map;
  logic [SW-1:0] score, escapes;
  logic          hit_ack;

  whack_game_engine #(
    .N_HOLES(N), .SCORE_W(SW), .GAME_CYCLES(100), .SPAWN_CYCLES(8),
    .MOLE_LIFE_CYCLES(20), .WIN_SCORE(3), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_pos(hit_pos),
    .game_state(game_state), .mole_map(mole_map), .score(score), .escapes(escapes),
    .hit_ack(hit_ack)
  );

  always #5 clk = ~clk;

  // mask: 0 state, 1 map, 2 score, 3 escapes, 4 expired wait bound, 5 ack queue drained
  typedef struct packed {
    logic [5:0] mask;
    logic [1:0] st;
    logic [3:0] mm;
    logic [3:0] mv;
    logic [7:0] sc;
    logic [7:0] esc;
    logic       ge;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    ack_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_score;
  int    idx;
  logic [15:0] m;

  // Reference LFSR and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m <= SEED;
    else     m <= (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000);
  end

  always @(negedge clk) begin
    exp_t  e;
    string n;
    int    a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e.mask[0]) begin
        checks++;
        if (game_state !== e.st) begin
          errors++; $display("FAIL %s game_state got %0d want %0d", n, game_state, e.st);
        end
      end
      if (e.mask[1]) begin
        checks++;
        if ((mole_map & e.mm) !== e.mv) begin
          errors++; $display("FAIL %s mole_map got %b (mask %b) want %b", n, mole_map, e.mm, e.mv);
        end
      end
      if (e.mask[2]) begin
        checks++;
        if (score !== e.sc) begin
          errors++; $display("FAIL %s score got %0d want %0d", n, score, e.sc);
        end
      end
      if (e.mask[3]) begin
        checks++;
        if (e.ge ? (escapes < e.esc) : (escapes !== e.esc)) begin
          errors++; $display("FAIL %s escapes got %0d want %s%0d", n, escapes, e.ge ? ">=" : "", e.esc);
        end
      end
      if (e.mask[4]) begin
        checks++; errors++; $display("FAIL %s wait bound expired got none want event", n);
      end
      if (e.mask[5]) begin
        checks++;
        if (ack_q.size() != 0) begin
          errors++; $display("FAIL %s pending hit_ack got %0d want 0", n, ack_q.size());
        end
      end
    end
    if (!rst) begin
      while (ack_q.size() > 0 && ack_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL hit_ack_missing got 0 at cycle %0d want 1", ack_q[0]);
        void'(ack_q.pop_front());
      end
      if (hit_ack) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++; $display("FAIL hit_ack_spurious at cycle %0d got 1 want 0", cyc);
        end else begin
          a = ack_q.pop_front();
          if (a != cyc) begin
            errors++; $display("FAIL hit_ack_timing got cycle %0d want cycle %0d", cyc, a);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string n, input logic [5:0] mask, input logic [1:0] st,
                     input logic [3:0] mm, input logic [3:0] mv, input int sc,
                     input int esc, input bit ge);
    exp_t e;
    e.mask = mask; e.st = st; e.mm = mm; e.mv = mv;
    e.sc = 8'(sc); e.esc = 8'(esc); e.ge = ge;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic spawn_idx_now(output int k);
    k = int'(m[1:0]);
    if (k >= int'(N)) k -= int'(N);
  endtask

  // Hit whichever mole is up (stimulus only); expected score comes from exp_score
  task automatic hit_any();
    int p;
    int w;
    p = 0;
    w = 0;
    while (mole_map == '0 && w < 40) begin step(); w++; end
    if (mole_map == '0) begin
      chk("hit_any_wait", 6'b010000, 2'd0, 4'h0, 4'h0, 0, 0, 1'b0);
      return;
    end
    for (int i = N - 1; i >= 0; i--) if (mole_map[i]) p = i;
    hit_valid = 1'b1; hit_pos = 2'(p);
    ack_q.push_back(cyc + 1);
    step();
    hit_valid = 1'b0;
    exp_score++;
    chk("hit_any", 6'b000111, 2'd1, 4'(1 << p), 4'h0, exp_score, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_pos = 2'd0;
    steps(3);
    rst = 1'b0;
    chk("reset", 6'b001111, 2'd0, 4'hF, 4'h0, 0, 0, 1'b0);

    // Game A: first spawn, hit, ignored start, miss, then win
    start = 1'b1; step(); start = 1'b0;
    chk("game_entry", 6'b001111, 2'd1, 4'hF, 4'h0, 0, 0, 1'b0);
    steps(7);
    spawn_idx_now(idx);
    chk("pre_spawn", 6'b000010, 2'd0, 4'hF, 4'h0, 0, 0, 1'b0);
    step();
    chk("first_spawn", 6'b000011, 2'd1, 4'hF, 4'(1 << idx), 0, 0, 1'b0);
    hit_valid = 1'b1; hit_pos = 2'(idx);
    ack_q.push_back(cyc + 1);
    step();
    hit_valid = 1'b0;
    exp_score = 1;
    chk("first_hit", 6'b000111, 2'd1, 4'hF, 4'h0, 1, 0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk("start_in_game", 6'b000101, 2'd1, 4'h0, 4'h0, 1, 0, 1'b0);
    hit_valid = 1'b1; hit_pos = 2'd3; step(); hit_valid = 1'b0;
`ifdef MISS_PENALTY_EN
    exp_score = 0;
`else
    exp_score = 1;
`endif
    chk("miss_hole3", 6'b000111, 2'd1, 4'hF, 4'h0, exp_score, 0, 1'b0);
    while (exp_score < 3) hit_any();
    step();
    chk("win", 6'b000111, 2'd2, 4'hF, 4'h0, 3, 0, 1'b0);
    steps(3);
    chk("win_hold", 6'b000111, 2'd2, 4'hF, 4'h0, 3, 0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk("win_to_idle", 6'b000111, 2'd0, 4'hF, 4'h0, 3, 0, 1'b0);
    hit_valid = 1'b1; hit_pos = 2'd0; step(); hit_valid = 1'b0;
    chk("idle_hit", 6'b000111, 2'd0, 4'hF, 4'h0, 3, 0, 1'b0);

    // Game B: hit in the expiry cycle, then time out
    start = 1'b1; step(); start = 1'b0;
    chk("entry_clear", 6'b001111, 2'd1, 4'hF, 4'h0, 0, 0, 1'b0);
    steps(7);
    spawn_idx_now(idx);
    steps(20);
    chk("pre_expiry", 6'b000010, 2'd0, 4'(1 << idx), 4'(1 << idx), 0, 0, 1'b0);
    hit_valid = 1'b1; hit_pos = 2'(idx);
    ack_q.push_back(cyc + 1);
    step();
    hit_valid = 1'b0;
    chk("hit_at_expiry", 6'b001110, 2'd0, 4'(1 << idx), 4'h0, 1, 0, 1'b0);
    steps(71);
    chk("last_game_cycle", 6'b000001, 2'd1, 4'h0, 4'h0, 0, 0, 1'b0);
    step();
    chk("lose", 6'b001111, 2'd3, 4'hF, 4'h0, 1, 1, 1'b1);
    steps(2);
    chk("lose_hold", 6'b000111, 2'd3, 4'hF, 4'h0, 1, 0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk("lose_to_idle", 6'b000011, 2'd0, 4'hF, 4'h0, 0, 0, 1'b0);

    // Game C: reset mid-game, then LFSR and counters restart from the seed
    start = 1'b1; step(); start = 1'b0;
    exp_score = 0;
    hit_any();
    hit_any();
    step();
    chk("pre_reset", 6'b000101, 2'd1, 4'h0, 4'h0, 2, 0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_reset", 6'b001111, 2'd0, 4'hF, 4'h0, 0, 0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    steps(7);
    spawn_idx_now(idx);
    step();
    chk("spawn_after_reset", 6'b000011, 2'd1, 4'hF, 4'(1 << idx), 0, 0, 1'b0);

    steps(2);
    chk("ack_drain", 6'b100000, 2'd0, 4'h0, 4'h0, 0, 0, 1'b0);
    steps(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
